// File: rtl/cmn_trace_pkg.sv
// Shared types and constants for the cmn_Trace line streamer.
// Holds the FSM encoding, ASCII codes and nibble-to-hex helper.
package cmn_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    BODY,
    EOL
  } state_e;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int CMN_TRACE_IDX_BITS = 16;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

endpackage

// File: rtl/cmn_trace_streamer_if.sv
// Trace-in and byte-out val/rdy channels of the streamer.
// master drives traces and accepts bytes; slave is the streamer.
interface cmn_trace_streamer_if #(
  parameter int NCHARS = 512
);
  logic                  trace_val;
  logic                  trace_rdy;
  logic [NCHARS*8-1:0]   trace_msg;
  logic [15:0]           trace_cyc;
  logic                  out_val;
  logic                  out_rdy;
  logic [7:0]            out_msg;

  modport master (
    output trace_val, trace_msg, trace_cyc, out_rdy,
    input  trace_rdy, out_val, out_msg
  );

  modport slave (
    input  trace_val, trace_msg, trace_cyc, out_rdy,
    output trace_rdy, out_val, out_msg
  );
endinterface

// File: rtl/cmn_trace_hex_digit.sv
// Combinational nibble to lowercase ASCII hex digit.
// Used on the prefix nibble currently being emitted.
module cmn_trace_hex_digit
  import cmn_trace_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);
  assign ascii_o = nibble_to_ascii(nib_i);
endmodule

// File: rtl/cmn_trace_streamer.sv
// Serialises one cmn_Trace buffer as "cccc: <body>\n".
// Body runs from char NCHARS-1 down to idx+1.
module cmn_trace_streamer
  import cmn_trace_pkg::*;
#(
  parameter int NCHARS   = 512,
  parameter int IDX_BITS = CMN_TRACE_IDX_BITS
) (
  input  logic                clk,
  input  logic                reset,
  cmn_trace_streamer_if.slave bus,
  output logic                busy
);

  localparam int PW = $clog2(NCHARS);
  localparam logic [IDX_BITS-1:0] LAST =
    IDX_BITS'(NCHARS - 1);

  state_e state_q, state_d;

  logic [NCHARS-1:0][7:0] buf_q, buf_d;
  logic [15:0]            cyc_q, cyc_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [IDX_BITS-1:0]    ptr_q, ptr_d;
  logic [2:0]             cnt_q, cnt_d;

  logic       accept;
  logic       beat;
  logic       empty;
  logic       last_pfx;
  logic       last_body;
  logic [3:0] nib;
  logic [7:0] hex_ch;

  assign accept    = bus.trace_val && bus.trace_rdy;
  assign beat      = bus.out_val && bus.out_rdy;
  assign empty     = idx_q >= LAST;
  assign last_pfx  = cnt_q == 3'd5;
  assign last_body = ptr_q == idx_q + IDX_BITS'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = PREFIX;
      PREFIX: if (beat && last_pfx)
                state_d = empty ? EOL : BODY;
      BODY:   if (beat && last_body) state_d = EOL;
      EOL:    if (beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
      cyc_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cyc_q <= cyc_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    buf_d = buf_q;
    cyc_d = cyc_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      accept: begin
        buf_d = bus.trace_msg;
        cyc_d = bus.trace_cyc;
        idx_d = bus.trace_msg[IDX_BITS-1:0];
        cnt_d = '0;
      end
      (beat && state_q == PREFIX): begin
        if (last_pfx) ptr_d = LAST;
        else          cnt_d = cnt_q + 3'd1;
      end
      (beat && state_q == BODY && !last_body):
        ptr_d = ptr_q - IDX_BITS'(1);
      default: ;
    endcase
  end

  always_comb begin
    nib = cyc_q[3:0];
    unique case (cnt_q)
      3'd0:    nib = cyc_q[15:12];
      3'd1:    nib = cyc_q[11:8];
      3'd2:    nib = cyc_q[7:4];
      default: nib = cyc_q[3:0];
    endcase
  end

  cmn_trace_hex_digit u_hex (
    .nib_i   (nib),
    .ascii_o (hex_ch)
  );

  always_comb begin
    bus.trace_rdy = state_q == IDLE;
    bus.out_val   = state_q != IDLE;
    busy          = state_q != IDLE;
    bus.out_msg   = 8'h00;
    unique case (state_q)
      IDLE:   bus.out_msg = 8'h00;
      PREFIX: begin
        if (cnt_q < 3'd4)       bus.out_msg = hex_ch;
        else if (cnt_q == 3'd4) bus.out_msg = ASCII_COLON;
        else                    bus.out_msg = ASCII_SPACE;
      end
      BODY:   bus.out_msg = buf_q[ptr_q[PW-1:0]];
      EOL:    bus.out_msg = ASCII_NL;
      default: bus.out_msg = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_cmn_trace_streamer.sv
// Directed bench for cmn_trace_streamer.
// Hand-computed byte lines, backpressure, back-to-back, reset.
module tb_cmn_trace_streamer;

  localparam int N = 512;

  logic clk;
  logic reset;
  logic busy;

  cmn_trace_streamer_if #(.NCHARS(N)) bus ();

  cmn_trace_streamer #(.NCHARS(N), .IDX_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         ncyc;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*8-1:0] mk(input logic [15:0] idx,
                                        input logic [7:0] c1,
                                        input logic [7:0] c2);
    logic [N*8-1:0] m;
    m = '0;
    m[(N-1)*8 +: 8] = c1;
    m[(N-2)*8 +: 8] = c2;
    m[15:0] = idx;
    return m;
  endfunction

  task automatic send(input logic [N*8-1:0] m,
                      input logic [15:0] c);
    bus.trace_val = 1'b1;
    bus.trace_msg = m;
    bus.trace_cyc = c;
    @(negedge clk);
    bus.trace_val = 1'b0;
  endtask

  task automatic collect(input bit bp, input int limit);
    bit         done;
    bit         stalled;
    logic [7:0] held;
    got.delete();
    ncyc = 0;
    done = 1'b0;
    stalled = 1'b0;
    held = 8'h00;
    while (!done && ncyc < limit) begin
      bus.out_rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (stalled) begin
        check("stall_val", {31'd0, bus.out_val}, 32'd1);
        check("stall_msg", {24'd0, bus.out_msg}, {24'd0, held});
      end
      if (bus.out_val && bus.out_rdy) begin
        got.push_back(bus.out_msg);
        if (bus.out_msg == 8'h0A) done = 1'b1;
      end
      stalled = bus.out_val && !bus.out_rdy;
      held = bus.out_msg;
      ncyc++;
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    check("line_done", {31'd0, done}, 32'd1);
  endtask

  task automatic cmp_line(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    reset = 1'b0;
    bus.trace_val = 1'b0;
    bus.trace_msg = '0;
    bus.trace_cyc = '0;
    bus.out_rdy = 1'b1;
    #1;
    check("rst_trdy", {31'd0, bus.trace_rdy}, 32'd1);
    check("rst_oval", {31'd0, bus.out_val}, 32'd0);
    check("rst_omsg", {24'd0, bus.out_msg}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: empty body
    send(mk(16'd511, 8'h5A, 8'h5A), 16'h002A);
    collect(1'b0, 40);
    exp_q = '{8'h30, 8'h30, 8'h32, 8'h61, 8'h3A, 8'h20, 8'h0A};
    cmp_line("t1");
    check("t1_cycles", ncyc, 32'd7);
    check("t1_trdy", {31'd0, bus.trace_rdy}, 32'd1);

    // 2: body "ab"
    send(mk(16'd509, 8'h61, 8'h62), 16'hBEEF);
    collect(1'b0, 40);
    exp_q = '{8'h62, 8'h65, 8'h65, 8'h66, 8'h3A, 8'h20,
              8'h61, 8'h62, 8'h0A};
    cmp_line("t2");
    check("t2_cycles", ncyc, 32'd9);

    // 3: backpressure
    send(mk(16'd509, 8'h61, 8'h62), 16'hBEEF);
    collect(1'b1, 300);
    cmp_line("t3");

    // 4: back-to-back, msg changed after accept
    bus.trace_val = 1'b1;
    bus.trace_msg = mk(16'd509, 8'h61, 8'h62);
    bus.trace_cyc = 16'h1234;
    @(negedge clk);
    bus.trace_msg = mk(16'd509, 8'h78, 8'h79);
    bus.trace_cyc = 16'h5678;
    check("t4_rdy_busy", {31'd0, bus.trace_rdy}, 32'd0);
    collect(1'b0, 40);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h3A, 8'h20,
              8'h61, 8'h62, 8'h0A};
    cmp_line("t4a");
    check("t4_bubble_rdy", {31'd0, bus.trace_rdy}, 32'd1);
    check("t4_bubble_val", {31'd0, bus.out_val}, 32'd0);
    @(negedge clk);
    bus.trace_val = 1'b0;
    check("t4_acc_next", {31'd0, bus.out_val}, 32'd1);
    collect(1'b0, 40);
    exp_q = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h3A, 8'h20,
              8'h78, 8'h79, 8'h0A};
    cmp_line("t4b");

    // 5: reset mid-body
    send(mk(16'd509, 8'h61, 8'h62), 16'hBEEF);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("t5_body", {24'd0, bus.out_msg}, 32'h61);
    check("t5_trdy0", {31'd0, bus.trace_rdy}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("t5_oval", {31'd0, bus.out_val}, 32'd0);
    check("t5_trdy", {31'd0, bus.trace_rdy}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_omsg", {24'd0, bus.out_msg}, 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(mk(16'd511, 8'h5A, 8'h5A), 16'h0C0D);
    collect(1'b0, 40);
    exp_q = '{8'h30, 8'h63, 8'h30, 8'h64, 8'h3A, 8'h20, 8'h0A};
    cmp_line("t5");

    // 6: out-of-range idx
    send(mk(16'hFFFF, 8'h5A, 8'h59), 16'h00FF);
    collect(1'b0, 40);
    exp_q = '{8'h30, 8'h30, 8'h66, 8'h66, 8'h3A, 8'h20, 8'h0A};
    cmp_line("t6a");
    check("t6a_cycles", ncyc, 32'd7);
    send(mk(16'd512, 8'h5A, 8'h59), 16'hA5C3);
    collect(1'b0, 40);
    exp_q = '{8'h61, 8'h35, 8'h63, 8'h33, 8'h3A, 8'h20, 8'h0A};
    cmp_line("t6b");
    check("t6b_cycles", ncyc, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
